pic_nchan: RTL
==============

PIC_NCHAN -- requirements
Module: pic_nchan

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, meaning the number of request lines (legal 2..16).
REQ-002 SHALL have parameter VEC_W, default 8, meaning the vector width.
REQ-003 SHALL have port iClk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iRW  input  2  bus strobe: bit1 read, bit0 write; one-cycle pulses.
REQ-006 SHALL have port iAddr  input  3  register select.
REQ-007 SHALL have port iData  input  16  write data.
REQ-008 SHALL have port oData  output  16  read data; bits at or above NUM_IRQ read 0.
REQ-009 SHALL have port oAck  output  1  bus acknowledge.
REQ-010 SHALL have port iReq  input  NUM_IRQ  interrupt requests.
REQ-011 SHALL have port oINT  output  1  interrupt to the CPU.
REQ-012 SHALL have port oINT_T  output  VEC_W  interrupt vector.
REQ-013 SHALL have port iAck  input  1  CPU interrupt acknowledge, level.

Function
REQ-014 Register map SHALL be: 0 CTRL (bit0 LTIM level mode, bit1 AEOI, bit2 ROT, bit3 RIS); 1 VBASE; 2 IMR; 3 EOI (write only); 4 IRR/ISR (read only, RIS selects ISR); 5 PRI (bottom-priority pointer, read only).
REQ-015 A read SHALL drive oData and oAck=1 on the next cycle; a write SHALL update the register and pulse oAck=1 on the next cycle.
REQ-016 Edge mode (LTIM=0) SHALL set IRR[i] on a registered 0->1 transition of iReq[i]; level mode SHALL make IRR[i] equal iReq[i], registered.
REQ-017 Candidates SHALL be IRR & ~IMR; the winner SHALL be the first candidate scanning upward, with wrap, from index PRI+1 mod NUM_IRQ.
REQ-018 A winner SHALL be issued only if its priority is higher than the highest-priority ISR bit (fully nested).
REQ-019 FSM IDLE: on a valid winner, move to REQ, set oINT=1 and oINT_T=VBASE+winner, and latch the winner index.
REQ-020 FSM REQ: on iAck=1, set ISR[latched], clear IRR[latched] (edge mode), and move to SERV; in AEOI mode, clear that ISR bit immediately instead.
REQ-021 FSM SERV: on iAck=0, drop oINT to 0 and move to IDLE.
REQ-022 Latency SHALL be: iReq edge in cycle n gives IRR set in n+1 and oINT=1 in n+2.
REQ-023 If the request vanishes in REQ (level mode, or IMR written), iAck SHALL still be honoured with the spurious vector VBASE+NUM_IRQ-1 and no ISR change.
REQ-024 EOI write, iData[15]=0 (nonspecific), SHALL clear the highest-priority ISR bit; iData[15]=1 (specific) SHALL clear ISR[iData[3:0]]; EOI with ISR empty SHALL be a no-op.
REQ-025 On EOI or AEOI with ROT=1, PRI SHALL become the cleared index.
REQ-026 When a request edge and a bus clear of the same IRR bit occur in one cycle, set SHALL win.
REQ-027 A CTRL write SHALL clear IRR, ISR and PRI and return the FSM to IDLE with oINT=0.

Reset
REQ-028 iRst SHALL set CTRL=0, VBASE=8, IMR=all ones, IRR=0, ISR=0, PRI=NUM_IRQ-1, FSM=IDLE, oINT=0, oINT_T=0, oData=0, oAck=0; asserting iRst mid-handshake SHALL abort it with no vector issued after release.

Configuration
REQ-029 Macro PIC_NCHAN_ROTATE_EN defined: ROT and the PRI update SHALL be as specified.
REQ-030 PIC_NCHAN_ROTATE_EN undefined: CTRL bit2 SHALL read 0, PRI SHALL stay NUM_IRQ-1 (fixed priority, index 0 highest), and the rotation logic SHALL be absent.

Structure
REQ-031 Package pic_pkg SHALL hold the register address constants, the CTRL bit positions, the FSM state enumeration and the reset values.
REQ-032 A combinational sub-module pic_prio_enc (inputs: vector and pointer; outputs: index and valid) SHALL resolve both the winner and the highest-priority ISR bit.

Verification
REQ-033 IMR=0, edge pulse on iReq[3] -> oINT=1 two cycles later, oINT_T=0x0B; iAck high then low -> ISR=0x0008, oINT=0.
REQ-034 iReq[5] and iReq[2] pending together under fixed priority -> vector 0x0A first; nonspecific EOI -> vector 0x0D.
REQ-035 ROT=1, service IRQ4, then EOI -> PRI=4; simultaneous IRQ2 and IRQ6 -> IRQ6 issued first.
REQ-036 Level mode, iReq[1] dropped while in REQ, then iAck -> oINT_T=VBASE+15, ISR unchanged.
REQ-037 ISR[2] set, IRQ7 raised -> oINT stays 0; IRQ0 raised -> nested vector VBASE+0 issued.
REQ-038 iRst pulsed during REQ -> oINT=0 next cycle, all registers at reset values, no vector after release.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants, state type and helpers for the pic_nchan interrupt controller.
package pic_pkg;

    localparam logic [2:0] ADDR_CTRL  = 3'd0;
    localparam logic [2:0] ADDR_VBASE = 3'd1;
    localparam logic [2:0] ADDR_IMR   = 3'd2;
    localparam logic [2:0] ADDR_EOI   = 3'd3;
    localparam logic [2:0] ADDR_STAT  = 3'd4;
    localparam logic [2:0] ADDR_PRI   = 3'd5;

    localparam int CTRL_LTIM = 0;
    localparam int CTRL_AEOI = 1;
    localparam int CTRL_ROT  = 2;
    localparam int CTRL_RIS  = 3;

    localparam logic [3:0] CTRL_RST  = 4'h0;
    localparam int         VBASE_RST = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERV
    } state_t;

    // Distance of idx from the top-priority slot ptr+1; smaller wins.
    function automatic logic [4:0] prio_rank(
        input logic [3:0] idx,
        input logic [3:0] ptr,
        input logic [4:0] n
    );
        logic [5:0] t;
        t = {2'b0, idx} + {1'b0, n} - {2'b0, ptr} - 6'd1;
        if (t >= {1'b0, n})
            t = t - {1'b0, n};
        return t[4:0];
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating priority encoder: first set bit scanning upward from ptr+1, wrapping at N.
module pic_prio_enc #(
    parameter int N = 16
) (
    input  logic [15:0] vec,
    input  logic [3:0]  ptr,
    output logic [3:0]  idx,
    output logic        valid
);

    localparam logic [4:0] NL = 5'(N);

    logic [4:0] j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr} + 5'd1 + 5'(k);
            if (j >= NL)
                j = j - NL;
            if (!valid && vec[j[3:0]]) begin
                valid = 1'b1;
                idx   = j[3:0];
            end
        end
    end

endmodule

// File: rtl/pic_nchan.sv
// N-channel nested interrupt controller with bus register file.
// Define PIC_NCHAN_ROTATE_EN to enable rotating priority (CTRL.ROT, PRI update).
module pic_nchan
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 16,
    parameter int VEC_W   = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [1:0]         iRW,
    input  logic [2:0]         iAddr,
    input  logic [15:0]        iData,
    output logic [15:0]        oData,
    output logic               oAck,
    input  logic [NUM_IRQ-1:0] iReq,
    output logic               oINT,
    output logic [VEC_W-1:0]   oINT_T,
    input  logic               iAck
);

    localparam logic [15:0] MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);
    localparam logic [3:0]  PRI_RST = 4'(NUM_IRQ - 1);
    localparam logic [4:0]  NL = 5'(NUM_IRQ);
    localparam logic [VEC_W-1:0] SPUR = VEC_W'(NUM_IRQ - 1);
`ifdef PIC_NCHAN_ROTATE_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] CTRL_WMASK = 4'hB;
`endif

    logic [3:0]       ctrl;
    logic [VEC_W-1:0] vbase;
    logic [15:0]      imr, irr, isr, req_q, req16;
    logic [15:0]      cand, rdata;
    logic [15:0]      isr_set, isr_clr, irr_set, irr_clr;
    logic [3:0]       pri, lat, win, top, clr_idx;
    logic             win_v, top_v, win_ok, clr_v;
    logic             rd, wr, wr_ctrl, wr_eoi, ltim, aeoi;
    logic             issue, acked, spur, drop;
    state_t           state, state_n;

    assign req16   = 16'(iReq);
    assign rd      = iRW[1];
    assign wr      = iRW[0];
    assign wr_ctrl = wr && (iAddr == ADDR_CTRL);
    assign wr_eoi  = wr && (iAddr == ADDR_EOI);
    assign ltim    = ctrl[CTRL_LTIM];
    assign aeoi    = ctrl[CTRL_AEOI];
    assign cand    = irr & ~imr;
    assign irr_set = ltim ? '0 : (req16 & ~req_q);

    pic_prio_enc #(.N(NUM_IRQ)) u_win (
        .vec   (cand),
        .ptr   (pri),
        .idx   (win),
        .valid (win_v)
    );

    pic_prio_enc #(.N(NUM_IRQ)) u_top (
        .vec   (isr),
        .ptr   (pri),
        .idx   (top),
        .valid (top_v)
    );

    // Fully nested: only a strictly higher priority than in-service may issue.
    assign win_ok = win_v && (!top_v ||
        (prio_rank(win, pri, NL) < prio_rank(top, pri, NL)));

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        acked   = 1'b0;
        spur    = 1'b0;
        drop    = 1'b0;
        unique case (state)
            ST_IDLE: if (win_ok) begin
                state_n = ST_REQ;
                issue   = 1'b1;
            end
            ST_REQ: if (iAck) begin
                state_n = ST_SERV;
                acked   = cand[lat];
                spur    = !cand[lat];
            end
            ST_SERV: if (!iAck) begin
                state_n = ST_IDLE;
                drop    = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        if (wr_ctrl)
            state_n = ST_IDLE;
    end

    always_comb begin
        isr_set = '0;
        irr_clr = '0;
        isr_clr = '0;
        clr_idx = top;
        clr_v   = 1'b0;
        if (acked && !aeoi)
            isr_set[lat] = 1'b1;
        if (acked && !ltim)
            irr_clr[lat] = 1'b1;
        if (wr_eoi) begin
            if (iData[15]) begin
                clr_idx = iData[3:0];
                clr_v   = isr[iData[3:0]];
            end else begin
                clr_v   = top_v;
            end
        end
        if (clr_v)
            isr_clr[clr_idx] = 1'b1;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (iAddr == ADDR_CTRL):  rdata = {12'b0, ctrl};
            (iAddr == ADDR_VBASE): rdata = 16'(vbase);
            (iAddr == ADDR_IMR):   rdata = imr;
            (iAddr == ADDR_STAT):  rdata = ctrl[CTRL_RIS] ? isr : irr;
            (iAddr == ADDR_PRI):   rdata = {12'b0, pri};
            default:               rdata = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= ST_IDLE;
            ctrl   <= CTRL_RST;
            vbase  <= VEC_W'(VBASE_RST);
            imr    <= MASK;
            irr    <= '0;
            isr    <= '0;
            req_q  <= '0;
            lat    <= '0;
            oINT   <= 1'b0;
            oINT_T <= '0;
            oData  <= '0;
            oAck   <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= req16;
            oAck  <= rd | wr;
            if (rd)
                oData <= rdata;
            if (wr && (iAddr == ADDR_VBASE))
                vbase <= iData[VEC_W-1:0];
            if (wr && (iAddr == ADDR_IMR))
                imr <= iData & MASK;
            if (issue)
                lat <= win;
            if (issue)
                oINT_T <= vbase + VEC_W'(win);
            else if (spur)
                oINT_T <= vbase + SPUR;
            // A CTRL write restarts the controller; a same-cycle edge still lands.
            if (wr_ctrl) begin
                ctrl <= iData[3:0] & CTRL_WMASK;
                irr  <= irr_set;
                isr  <= '0;
                oINT <= 1'b0;
            end else begin
                irr <= ltim ? req16 : ((irr & ~irr_clr) | irr_set);
                isr <= (isr | isr_set) & ~isr_clr;
                if (issue)
                    oINT <= 1'b1;
                else if (drop)
                    oINT <= 1'b0;
            end
        end
    end

`ifdef PIC_NCHAN_ROTATE_EN
    logic rot;
    assign rot = ctrl[CTRL_ROT];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            pri <= PRI_RST;
        else if (wr_ctrl)
            pri <= PRI_RST;
        else if (rot && clr_v)
            pri <= clr_idx;
        else if (rot && acked && aeoi)
            pri <= lat;
    end
`else
    assign pri = PRI_RST;
`endif

endmodule
